ham_encoder_tx: RTL and testbench

HAM_ENCODER_TX -- requirements
Module: ham_encoder_tx

---
 rtl/ham_pkg.sv | 27 ++
 rtl/ham_encode.sv | 23 ++
 rtl/ham_encoder_tx.sv | 138 +++++++++++++
 tb/tb_ham_encoder_tx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ham_pkg.sv
// Shared definitions for the Hamming(7,4) transmitter.
// Holds the codeword/nibble types, bit-position constants for the parity and
// data fields of the codeword, and the transmitter state encoding.
package ham_pkg;

    localparam int CW_BITS = 7;

    typedef logic [CW_BITS-1:0] codeword_t;
    typedef logic [3:0]         nibble_t;

    // Parity bits sit at the power-of-two positions (1-based 1, 2, 4).
    localparam int P0_POS = 0;
    localparam int P1_POS = 1;
    localparam int P2_POS = 3;

    // Data bits fill the remaining positions in ascending order.
    localparam int D0_POS = 2;
    localparam int D1_POS = 4;
    localparam int D2_POS = 5;
    localparam int D3_POS = 6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } tx_state_e;

endpackage

// File: rtl/ham_encode.sv
// Combinational Hamming(7,4) encoder.
// Ports:
//   data_i : nibble d[3:0] to encode
//   cw_o   : clean codeword e[6:0] (syndrome 3'b000)
module ham_encode
    import ham_pkg::*;
(
    input  nibble_t   data_i,
    output codeword_t cw_o
);

    always_comb begin
        cw_o         = '0;
        cw_o[D0_POS] = data_i[0];
        cw_o[D1_POS] = data_i[1];
        cw_o[D2_POS] = data_i[2];
        cw_o[D3_POS] = data_i[3];
        cw_o[P0_POS] = data_i[3] ^ data_i[1] ^ data_i[0];
        cw_o[P1_POS] = data_i[3] ^ data_i[2] ^ data_i[0];
        cw_o[P2_POS] = data_i[3] ^ data_i[2] ^ data_i[1];
    end

endmodule

// File: rtl/ham_encoder_tx.sv
// Hamming(7,4) encoder with error injection and a serial transmitter.
// A nibble is accepted when in_valid && in_ready; its codeword (XORed with
// err_mask) is presented in parallel on cw_out and shifted out serially, each
// bit held CLKS_PER_BIT cycles, in LSB-first or MSB-first order.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : input handshake for data_in / err_mask
//   data_in, err_mask  : nibble and codeword error-injection mask
//   cw_out, cw_valid   : registered transmitted codeword, one-cycle update pulse
//   ser_out, ser_valid : serial bit and its qualifier
//   ser_last           : high during the 7th serial bit
//   busy               : frame in progress
module ham_encoder_tx
    import ham_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] data_in,
    input  logic [6:0] err_mask,
    output logic [6:0] cw_out,
    output logic       cw_valid,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       ser_last,
    output logic       busy
);

    localparam logic [7:0] HOLD_MAX = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_IDX = 3'(CW_BITS - 1);

    tx_state_e state_q;
    codeword_t cw_q;
    codeword_t shreg_q;
    codeword_t shreg_d;
    logic      cw_valid_q;
    logic      ser_out_q;
    logic      ser_valid_q;
    logic      ser_last_q;
    logic [2:0] bit_idx_q;
    logic [7:0] hold_q;

    codeword_t clean_cw;
    codeword_t tx_word;
    logic      accept;
    logic      first_bit;
    logic      next_bit;

    ham_encode u_encode (
        .data_i (data_in),
        .cw_o   (clean_cw)
    );

    assign tx_word  = clean_cw ^ err_mask;
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;

    // The shift register always presents the bit after the one on ser_out
    // at a fixed position, so the next bit is a constant tap.
    always_comb begin
        shreg_d   = shreg_q;
        first_bit = 1'b0;
        next_bit  = 1'b0;
        if (LSB_FIRST) begin
            shreg_d   = {1'b0, shreg_q[CW_BITS-1:1]};
            first_bit = tx_word[0];
            next_bit  = shreg_q[1];
        end else begin
            shreg_d   = {shreg_q[CW_BITS-2:0], 1'b0};
            first_bit = tx_word[CW_BITS-1];
            next_bit  = shreg_q[CW_BITS-2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cw_q        <= '0;
            shreg_q     <= '0;
            cw_valid_q  <= 1'b0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_last_q  <= 1'b0;
            bit_idx_q   <= '0;
            hold_q      <= '0;
        end else begin
            cw_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_SHIFT;
                        cw_q        <= tx_word;
                        shreg_q     <= tx_word;
                        cw_valid_q  <= 1'b1;
                        ser_out_q   <= first_bit;
                        ser_valid_q <= 1'b1;
                        ser_last_q  <= 1'b0;
                        bit_idx_q   <= '0;
                        hold_q      <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (hold_q == HOLD_MAX) begin
                        hold_q <= '0;
                        if (bit_idx_q == LAST_IDX) begin
                            state_q     <= ST_IDLE;
                            ser_out_q   <= 1'b0;
                            ser_valid_q <= 1'b0;
                            ser_last_q  <= 1'b0;
                            bit_idx_q   <= '0;
                        end else begin
                            bit_idx_q  <= bit_idx_q + 3'd1;
                            shreg_q    <= shreg_d;
                            ser_out_q  <= next_bit;
                            // Moving onto the final bit.
                            ser_last_q <= (bit_idx_q == LAST_IDX - 3'd1);
                        end
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cw_out    = cw_q;
    assign cw_valid  = cw_valid_q;
    assign ser_out   = ser_out_q;
    assign ser_valid = ser_valid_q;
    assign ser_last  = ser_last_q;
    assign busy      = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_ham_encoder_tx.sv
// Testbench for ham_encoder_tx: two instances (1 clk/bit LSB-first and
// 3 clk/bit MSB-first) checked against a Hamming reference model.
module tb_ham_encoder_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid  [2];
    logic [3:0] data_in   [2];
    logic [6:0] err_mask  [2];
    logic       in_ready  [2];
    logic [6:0] cw_out    [2];
    logic       cw_valid  [2];
    logic       ser_out   [2];
    logic       ser_valid [2];
    logic       ser_last  [2];
    logic       busy      [2];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    ham_encoder_tx #(.CLKS_PER_BIT(1), .LSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .data_in(data_in[0]), .err_mask(err_mask[0]), .cw_out(cw_out[0]),
        .cw_valid(cw_valid[0]), .ser_out(ser_out[0]), .ser_valid(ser_valid[0]),
        .ser_last(ser_last[0]), .busy(busy[0])
    );

    ham_encoder_tx #(.CLKS_PER_BIT(3), .LSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .data_in(data_in[1]), .err_mask(err_mask[1]), .cw_out(cw_out[1]),
        .cw_valid(cw_valid[1]), .ser_out(ser_out[1]), .ser_valid(ser_valid[1]),
        .ser_last(ser_last[1]), .busy(busy[1])
    );

    // ---------------- reference model ----------------
    // Classic Hamming rule on 1-based positions: data fills non-power-of-two
    // positions, parity at position p covers every position whose index has bit p.
    function automatic logic [6:0] ref_encode(input logic [3:0] d);
        logic [6:0] e;
        int k;
        logic par;
        e = '0;
        k = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                e[pos-1] = d[k];
                k++;
            end
        end
        for (int p = 1; p <= 4; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++)
                if (pos != p && (pos & p) != 0) par = par ^ e[pos-1];
            e[p-1] = par;
        end
        return e;
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] e);
        int s;
        s = 0;
        for (int pos = 1; pos <= 7; pos++)
            if (e[pos-1]) s = s ^ pos;
        return 3'(s);
    endfunction

    function automatic logic [3:0] recover(input logic [6:0] e);
        logic [3:0] d;
        int k;
        d = '0;
        k = 0;
        for (int pos = 1; pos <= 7; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[k] = e[pos-1];
                k++;
            end
        end
        return d;
    endfunction

    function automatic int cpb_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Send one nibble on DUT k and verify the full frame against the model.
    // got7[j] is the j-th transmitted bit.
    task automatic run_frame(input int k, input logic [3:0] d, input logic [6:0] m,
                             output logic [6:0] cw_got, output logic [6:0] got7,
                             output int nvalid);
        int cpb, w, ready_lat, extra;
        logic [6:0] exp;
        logic [31:0] got_bits, got_last, exp_bits, exp_last;
        cpb = cpb_of(k);
        exp = ref_encode(d) ^ m;
        got_bits = '0; got_last = '0; exp_bits = '0; exp_last = '0;
        nvalid = 0; ready_lat = 0; extra = 0; w = 0;
        cw_got = '0;
        got7 = '0;

        @(negedge clk);
        data_in[k]  = d;
        err_mask[k] = m;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_send", 32'(in_ready[k]), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;

        for (int c = 1; c <= 7 * cpb + 1; c++) begin
            if (c == 1) begin
                cw_got = cw_out[k];
                check("cw_out", 32'(cw_out[k]), 32'(exp));
                check("cw_valid_first", 32'(cw_valid[k]), 32'd1);
            end else if (cw_valid[k]) begin
                extra++;
            end
            if (c == 2) begin
                data_in[k]  = 4'($urandom);
                err_mask[k] = 7'($urandom);
            end
            if (ser_valid[k]) nvalid++;
            if (c <= 7 * cpb) begin
                got_bits[c-1] = ser_out[k];
                got_last[c-1] = ser_last[k];
            end
            if (in_ready[k] && ready_lat == 0) ready_lat = c;
            if (c <= 7 * cpb) @(negedge clk);
        end

        for (int i = 0; i < 7 * cpb; i++) begin
            exp_bits[i] = (k == 0) ? exp[i / cpb] : exp[6 - i / cpb];
            exp_last[i] = ((i / cpb) == 6);
        end
        for (int j = 0; j < 7; j++) got7[j] = got_bits[j * cpb];

        check("ser_bits", got_bits, exp_bits);
        check("ser_last", got_last, exp_last);
        check("ser_valid_len", 32'(nvalid), 32'(7 * cpb));
        check("ready_latency", 32'(ready_lat), 32'(7 * cpb + 1));
        check("cw_valid_extra", 32'(extra), 32'd0);
        check("idle_outputs", {29'd0, ser_out[k], ser_last[k], busy[k]}, 32'd0);
        repeat (2) @(negedge clk);
        check("cw_retained", 32'(cw_out[k]), 32'(exp));
        $display("[TB] dut%0d d=%h mask=%h cw=%h bits=%b", k, d, m, cw_got, got7);
    endtask

    // Hold in_valid high across two frames: nibble A then 5.
    task automatic back_to_back(input int k);
        int cpb, n;
        int t [2];
        logic [6:0] c [2];
        cpb = cpb_of(k);
        n = 0;
        t[0] = 0; t[1] = 0; c[0] = '0; c[1] = '0;
        @(negedge clk);
        data_in[k]  = 4'hA;
        err_mask[k] = 7'd0;
        in_valid[k] = 1'b1;
        for (int i = 0; i < 2 * (7 * cpb + 1) + 6; i++) begin
            @(negedge clk);
            if (cw_valid[k]) begin
                if (n < 2) begin
                    t[n] = cyc;
                    c[n] = cw_out[k];
                end
                n++;
                if (n == 1) data_in[k] = 4'h5;
                else        in_valid[k] = 1'b0;
            end
        end
        in_valid[k] = 1'b0;
        check("b2b_frames", 32'(n), 32'd2);
        check("b2b_spacing", 32'(t[1] - t[0]), 32'(7 * cpb + 1));
        check("b2b_cw0", 32'(c[0]), 32'(ref_encode(4'hA)));
        check("b2b_cw1", 32'(c[1]), 32'(ref_encode(4'h5)));
        $display("[TB] dut%0d back-to-back frames=%0d spacing=%0d", k, n, t[1] - t[0]);
    endtask

    // Reset in the middle of bit index 3.
    task automatic reset_mid_frame(input int k);
        int cpb, w, residual;
        logic [3:0] d;
        logic [6:0] exp;
        cpb = cpb_of(k);
        d = 4'($urandom);
        exp = ref_encode(d);
        w = 0;
        residual = 0;
        @(negedge clk);
        data_in[k]  = d;
        err_mask[k] = 7'd0;
        in_valid[k] = 1'b1;
        while (!in_ready[k] && w < 100) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid[k] = 1'b0;
        repeat (3 * cpb) @(negedge clk);
        check("rst_pre_bit3", {30'd0, ser_valid[k], ser_out[k]},
              {30'd0, 1'b1, ((k == 0) ? exp[3] : exp[3])});
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_cw_out", 32'(cw_out[k]), 32'd0);
        check("rst_outputs", {26'd0, cw_valid[k], ser_out[k], ser_valid[k],
                              ser_last[k], busy[k], in_ready[k]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(in_ready[k]), 32'd1);
        for (int i = 0; i < 7 * cpb + 2; i++) begin
            if (ser_valid[k] || cw_valid[k] || busy[k]) residual++;
            @(negedge clk);
        end
        check("rst_no_residual", 32'(residual), 32'd0);
        $display("[TB] dut%0d reset at bit 3, residual=%0d", k, residual);
    endtask

    typedef struct {
        logic [3:0] d;
        logic [6:0] m;
        logic [6:0] cw;
        logic [2:0] syn;
    } vec_t;

    vec_t vecs [6];

    initial begin
        logic [6:0] cw_got, got7, m;
        int nv, k, sel;

        vecs[0] = '{d: 4'b1011, m: 7'b0000000, cw: 7'b1010101, syn: 3'b000};
        vecs[1] = '{d: 4'b0001, m: 7'b0000000, cw: 7'b0000111, syn: 3'b000};
        vecs[2] = '{d: 4'b1011, m: 7'b0010000, cw: 7'b1000101, syn: 3'b101};
        vecs[3] = '{d: 4'b0000, m: 7'b0000000, cw: 7'b0000000, syn: 3'b000};
        vecs[4] = '{d: 4'b1111, m: 7'b0000000, cw: 7'b1111111, syn: 3'b000};
        vecs[5] = '{d: 4'b0010, m: 7'b0000001, cw: 7'b0011000, syn: 3'b001};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i] = 1'b0;
            data_in[i]  = '0;
            err_mask[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("reset_cw_out", 32'(cw_out[i]), 32'd0);
            check("reset_outputs", {26'd0, cw_valid[i], ser_out[i], ser_valid[i],
                                    ser_last[i], busy[i], in_ready[i]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset0", 32'(in_ready[0]), 32'd1);
        check("ready_after_reset1", 32'(in_ready[1]), 32'd1);

        // Table vectors on the 1 clk/bit instance.
        for (int i = 0; i < 6; i++) begin
            run_frame(0, vecs[i].d, vecs[i].m, cw_got, got7, nv);
            check("table_cw", 32'(cw_got), 32'(vecs[i].cw));
            check("table_syn", 32'(syndrome(cw_got)), 32'(vecs[i].syn));
        end

        // Serial order corner cases.
        run_frame(0, 4'b0001, 7'd0, cw_got, got7, nv);
        check("seq_lsb_0001", 32'(got7), 32'b0000111);
        run_frame(1, 4'b1011, 7'd0, cw_got, got7, nv);
        check("seq_msb_1011", 32'(got7), 32'b1010101);
        check("valid_21", 32'(nv), 32'd21);

        // Exhaustive loopback.
        for (int d = 0; d < 16; d++) begin
            run_frame(0, 4'(d), 7'd0, cw_got, got7, nv);
            check("loop_syn", 32'(syndrome(cw_got)), 32'd0);
            check("loop_data", 32'(recover(cw_got)), 32'(d));
        end

        // Randomized frames on both instances.
        for (int i = 0; i < 24; i++) begin
            k = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      m = 7'd0;
            else if (sel == 1) m = 7'(1 << $urandom_range(0, 6));
            else               m = 7'($urandom);
            run_frame(k, 4'($urandom), m, cw_got, got7, nv);
            check("rand_syn", 32'(syndrome(cw_got)), 32'(syndrome(m)));
        end

        back_to_back(0);
        back_to_back(1);
        reset_mid_frame(0);
        reset_mid_frame(1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
